// File: rtl/div_pkg.sv
// Shared constants for the restoring divider: FSM encoding, counter width, divide-by-zero quotient.
// Latency: none (package only).
// Backpressure: not applicable.
//
// Contents: DIV_WIDTH, DIV_CNT_W, S_IDLE/S_RUN/S_FIN, DIV_DBZ_QUOT, and cla_carry(), which gives
// the carry into bit k (k=0..3) of a 4-bit carry-lookahead group, or the group carry-out for k=4.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUOT = '1;

  function automatic logic cla_carry(input logic [3:0] g, input logic [3:0] p,
                                     input logic cin, input int unsigned k);
    logic c;
    case (k)
      0: c = cin;
      1: c = g[0] | (p[0] & cin);
      2: c = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      3: c = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      default: c = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                   | (&p & cin);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Combinational W-bit subtract a - b built from 4-bit carry-lookahead groups, with borrow-out.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
//
// Ports: a, b (W bits, unsigned minuend/subtrahend); diff (low W-1 bits of a - b);
//        borrow (1 when a < b).
// Subtraction is a + ~b + 1: the subtrahend is inverted and the first group's carry-in is 1.
// Operands are zero-extended to whole nibbles; a carry out of the top group means no borrow.
// Only the low W-1 difference bits are returned: the divider keeps the difference only when
// there is no borrow, and then it is below the divisor, so the top bit is always 0.
module div_sub_stage
  import div_pkg::*;
#(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-2:0] diff,
  output logic         borrow
);

  localparam int NB = (W + 3) / 4;
  localparam int EW = NB * 4;

  logic [EW-1:0] x, y, g, p;
  logic [NB:0]   c;

  assign x    = EW'(a);
  assign y    = ~(EW'(b));
  assign g    = x & y;
  assign p    = x ^ y;
  assign c[0] = 1'b1;

  for (genvar n = 0; n < NB; n++) begin : g_nib
    assign c[n+1] = cla_carry(g[4*n +: 4], p[4*n +: 4], c[n], 4);
    for (genvar k = 0; k < 4; k++) begin : g_bit
      if (4*n + k < W - 1) begin : g_out
        assign diff[4*n+k] = p[4*n+k] ^ cla_carry(g[4*n +: 4], p[4*n +: 4], c[n], k);
      end
    end
  end

  assign borrow = ~c[NB];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/busy/done handshake.
// Latency: done WIDTH+1 cycles after an accepted start; 1 cycle for a zero divisor.
// Backpressure: start is accepted only in IDLE; a start while busy or during done is dropped.
//
// Ports: clk, rst (async active-high); start, dividend, divisor in; busy, done, quotient,
//        remainder, div_by_zero out. Optional macro DIV_SIGNED_EN adds input signed_op for
//        truncating two's-complement division (sign fix-up applied in the FIN cycle).
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic [1:0]           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0]     r_q, q_q, dvs_q, quot_q, rem_q;
  logic                 dbz_q;
  logic [WIDTH:0]       shifted;
  logic [WIDTH-1:0]     t_low;
  logic                 borrow;
  logic                 accept;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     fin_quot, fin_rem;

  assign accept  = (state_q == S_IDLE) && start;
  // Partial remainder shifted left with the next dividend bit; WIDTH+1 bits so R's MSB is kept.
  assign shifted = {r_q, q_q[WIDTH-1]};

  div_sub_stage #(.W(WIDTH + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs_q}),
    .diff   (t_low),
    .borrow (borrow)
  );

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_r_q;

  always_comb begin
    a_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    b_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept) begin
      neg_q_q <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r_q <= signed_op && dividend[WIDTH-1];
    end
  end

  // Divide-by-zero results are published raw; only real quotients get the sign fix-up.
  always_comb begin
    fin_quot = (!dbz_q && neg_q_q) ? -q_q : q_q;
    fin_rem  = (!dbz_q && neg_r_q) ? -r_q : r_q;
  end
`else
  assign a_mag    = dividend;
  assign b_mag    = divisor;
  assign fin_quot = q_q;
  assign fin_rem  = r_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (divisor == '0) ? S_FIN : S_RUN;
      S_RUN:  if (cnt_q == '0) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_FIN);
  end

  // Results appear combinationally in FIN and are then held in quot_q/rem_q.
  assign quotient    = (state_q == S_FIN) ? fin_quot : quot_q;
  assign remainder   = (state_q == S_FIN) ? fin_rem  : rem_q;
  assign div_by_zero = dbz_q;

  // Datapath: operand capture, one restoring step per RUN cycle, result publish in FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      dvs_q  <= '0;
      dbz_q  <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q <= DIV_CNT_W'(WIDTH - 1);
            dvs_q <= b_mag;
            dbz_q <= (divisor == '0);
            if (divisor == '0) begin
              q_q <= DIV_DBZ_QUOT;
              r_q <= dividend;
            end else begin
              q_q <= a_mag;
              r_q <= '0;
            end
          end
        end
        S_RUN: begin
          r_q   <= borrow ? shifted[WIDTH-1:0] : t_low;
          q_q   <= {q_q[WIDTH-2:0], ~borrow};
          cnt_q <= cnt_q - 1'b1;
        end
        S_FIN: begin
          quot_q <= fin_quot;
          rem_q  <= fin_rem;
        end
        default: ;
      endcase
    end
  end

endmodule
